// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding,
// PC increment and default reset/exception addresses.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HOLD  = 2'd3
    } pc_state_t;

    localparam logic [31:0] PC_INC             = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h8000_0180;

endpackage

// File: rtl/pc_sequencer_next_pc_sel.sv
// Next-PC source select: exception vector > jump > branch > sequential PC.
// Purely combinational; the caller decides when the result is loaded.
module next_pc_sel (
    input  logic        i_exc_sel,
    input  logic [31:0] i_exc_vector,
    input  logic        i_jump,
    input  logic [25:0] i_jump_index,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_next_pc
);

    logic [31:0] w_jump_addr;
    logic [31:0] w_branch_addr;

    // Jump keeps the 256 MB region of the delay-slot PC; branch targets are
    // word-aligned by clearing the two low bits.
    assign w_jump_addr   = {i_pc4[31:28], i_jump_index, 2'b00};
    assign w_branch_addr = i_branch_target & 32'hFFFF_FFFC;

    // Fixed-priority select, sequential PC by default.
    always_comb begin
        o_next_pc = i_pc4;
        if (i_exc_sel) begin
            o_next_pc = i_exc_vector;
        end else if (i_jump) begin
            o_next_pc = w_jump_addr;
        end else if (i_branch_taken) begin
            o_next_pc = w_branch_addr;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, runs the instruction-fetch
// handshake and presents each fetched instruction for one cycle.
// Optional feature macro: PC_EXCEPTION_EN adds exc_req/epc and the
// exception-vector redirect.
//
// state | meaning
// IDLE  | after reset, outputs inactive, moves to FETCH next edge
// FETCH | fetch_req high at pc, waits for fetch_ack
// EXEC  | instr_valid pulse, controls sampled, pc advances unless stalled
// HOLD  | stalled, waits for stall low, then advances pc
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        stall
`ifdef PC_EXCEPTION_EN
    ,
    input  logic        exc_req,
    output logic [31:0] epc
`endif
);

    pc_state_t   r_state;
    pc_state_t   w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc4;
    logic [31:0] w_next_pc;
    logic        w_pc_load;
    logic        w_exc_req;
    logic        w_ctrl_window;

`ifdef PC_EXCEPTION_EN
    logic [31:0] r_epc;
    assign w_exc_req = exc_req;
    assign epc       = r_epc;
`else
    assign w_exc_req = 1'b0;
`endif

    assign w_pc4         = r_pc + PC_INC;
    assign w_ctrl_window = (r_state == EXEC) || (r_state == HOLD);

    next_pc_sel u_next_pc_sel (
        .i_exc_sel       (w_exc_req),
        .i_exc_vector    (EXC_VECTOR),
        .i_jump          (jump),
        .i_jump_index    (jump_index),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_pc4           (w_pc4),
        .o_next_pc       (w_next_pc)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC register; loads only when the FSM commits a new address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (w_pc_load) begin
            r_pc <= w_next_pc;
        end
    end

`ifdef PC_EXCEPTION_EN
    // Capture the faulting PC when an exception is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_epc <= 32'h0000_0000;
        end else if (w_ctrl_window && w_exc_req) begin
            r_epc <= r_pc;
        end
    end
`endif

    // Next-state and PC-load decision. EXEC and HOLD share one rule: an
    // exception or an unstalled cycle commits next_pc, otherwise park in HOLD.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_load   = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (fetch_ack) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC, HOLD: begin
                if (w_exc_req || !stall) begin
                    w_pc_load   = 1'b1;
                    w_state_nxt = FETCH;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign fetch_req   = (r_state == FETCH);
    assign fetch_addr  = r_pc;
    assign instr_valid = (r_state == EXEC);
    assign pc          = r_pc;
    assign pc4         = w_pc4;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// instruction stream checked against a transaction-level PC model.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        stall;

    logic        w_fetch_req;
    logic [31:0] w_fetch_addr;
    logic        w_instr_valid;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic        w_ack;
    logic        w_zero;
    logic [31:0] w_zero32;
    logic [25:0] w_zero26;

`ifdef PC_EXCEPTION_EN
    logic        exc_req;
    logic [31:0] epc;
    logic [31:0] w_epc;
`endif

    int          n_cmp;
    int          n_fail;
    logic [31:0] mpc;

    pc_sequencer u_dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_ack     (fetch_ack),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc4           (pc4),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .stall         (stall)
`ifdef PC_EXCEPTION_EN
        ,
        .exc_req       (exc_req),
        .epc           (epc)
`endif
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk           (clk),
        .reset         (reset),
        .fetch_req     (w_fetch_req),
        .fetch_addr    (w_fetch_addr),
        .fetch_ack     (w_ack),
        .instr_valid   (w_instr_valid),
        .pc            (w_pc),
        .pc4           (w_pc4),
        .branch_taken  (w_zero),
        .branch_target (w_zero32),
        .jump          (w_zero),
        .jump_index    (w_zero26),
        .stall         (w_zero)
`ifdef PC_EXCEPTION_EN
        ,
        .exc_req       (w_zero),
        .epc           (w_epc)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural next-PC rule written with plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic j,
                                             input logic [25:0] idx, input logic b,
                                             input logic [31:0] t);
        logic [31:0] seq;
        seq = p + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ({6'd0, idx} << 2);
        if (b) return t & 32'hFFFF_FFFC;
        return seq;
    endfunction

    task automatic wait_fetch();
        int w;
        w = 0;
        while (fetch_req !== 1'b1 && w < 10) begin
            step();
            w++;
        end
        check("req_wait", {31'd0, fetch_req}, 32'd1);
    endtask

    // One instruction: fetch with ack latency, EXEC, optional stall cycles.
    task automatic do_instr(input int ack_dly, input logic j, input logic [25:0] idx,
                            input logic br, input logic [31:0] tgt, input int nstall);
        wait_fetch();
        for (int d = 0; d < ack_dly; d++) begin
            check("req_hold", {31'd0, fetch_req}, 32'd1);
            check("addr_hold", fetch_addr, mpc);
            check("iv_in_fetch", {31'd0, instr_valid}, 32'd0);
            jump         = 1'($urandom);
            branch_taken = 1'($urandom);
            step();
        end
        check("fetch_addr", fetch_addr, mpc);
        fetch_ack    = 1'b1;
        jump         = 1'b0;
        branch_taken = 1'b0;
        step();
        fetch_ack = 1'b0;
        check("exec_iv", {31'd0, instr_valid}, 32'd1);
        check("exec_req", {31'd0, fetch_req}, 32'd0);
        check("exec_pc", pc, mpc);
        check("exec_pc4", pc4, mpc + 32'd4);
        if (nstall == 0) begin
            stall = 1'b0; jump = j; jump_index = idx; branch_taken = br; branch_target = tgt;
        end else begin
            stall = 1'b1; jump = 1'b1; branch_taken = 1'b1;
            jump_index = 26'($urandom); branch_target = $urandom;
        end
        step();
        for (int k = 1; k <= nstall; k++) begin
            check("hold_iv", {31'd0, instr_valid}, 32'd0);
            check("hold_req", {31'd0, fetch_req}, 32'd0);
            check("hold_pc", pc, mpc);
            if (k == nstall) begin
                stall = 1'b0; jump = j; jump_index = idx; branch_taken = br; branch_target = tgt;
            end else begin
                jump_index = 26'($urandom); branch_target = $urandom;
            end
            fetch_ack = 1'($urandom);
            step();
        end
        fetch_ack = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        mpc = ref_next(mpc, j, idx, br, tgt);
        check("refetch_req", {31'd0, fetch_req}, 32'd1);
        check("next_pc", pc, mpc);
    endtask

`ifdef PC_EXCEPTION_EN
    task automatic exc_instr(input bit in_hold);
        logic [31:0] old_pc;
        old_pc = mpc;
        wait_fetch();
        check("exc_fetch_addr", fetch_addr, mpc);
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
        if (in_hold) begin
            stall = 1'b1;
            step();
            check("exc_hold_req", {31'd0, fetch_req}, 32'd0);
        end
        exc_req = 1'b1; stall = 1'b1; jump = 1'b1; branch_taken = 1'b1;
        step();
        exc_req = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        mpc = 32'h8000_0180;
        check("exc_epc", epc, old_pc);
        check("exc_req_after", {31'd0, fetch_req}, 32'd1);
        check("exc_vector", fetch_addr, 32'h8000_0180);
    endtask
`endif

    initial begin
        n_cmp = 0; n_fail = 0; mpc = 32'h0;
        reset = 1'b1; fetch_ack = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_index = 26'h0; stall = 1'b0;
        w_ack = 1'b1; w_zero = 1'b0; w_zero32 = 32'h0; w_zero26 = 26'h0;
`ifdef PC_EXCEPTION_EN
        exc_req = 1'b0;
`endif
        step();
        step();
        check("rst_req", {31'd0, fetch_req}, 32'd0);
        check("rst_iv", {31'd0, instr_valid}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        check("rst_wrap_pc4", w_pc4, 32'h0);
`ifdef PC_EXCEPTION_EN
        check("rst_epc", epc, 32'h0);
        check("rst_wrap_epc", w_epc, 32'h0);
`endif
        reset = 1'b0;
        step();
        check("first_req", {31'd0, fetch_req}, 32'd1);
        check("wrap_req", {31'd0, w_fetch_req}, 32'd1);
        check("wrap_addr0", w_fetch_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_iv", {31'd0, w_instr_valid}, 32'd1);
        step();
        check("wrap_addr1", w_fetch_addr, 32'h0000_0000);
        check("wrap_req1", {31'd0, w_fetch_req}, 32'd1);

        // Free-run: addresses 0, 4, 8 with back-to-back acknowledges.
        do_instr(0, 1'b0, 26'h0, 1'b0, 32'h0, 0);
        do_instr(0, 1'b0, 26'h0, 1'b0, 32'h0, 0);
        do_instr(0, 1'b0, 26'h0, 1'b0, 32'h0, 0);
        check("seq_addr_c", fetch_addr, 32'hC);

`ifdef PC_EXCEPTION_EN
        while (mpc != 32'h20) do_instr(0, 1'b0, 26'h0, 1'b0, 32'h0, 0);
        exc_instr(1'b0);
        exc_instr(1'b1);
`endif

        // Branch alignment and jump-over-branch priority.
        do_instr(1, 1'b0, 26'h0, 1'b1, 32'h0000_0100, 0);
        check("pc_at_100", fetch_addr, 32'h100);
        do_instr(0, 1'b0, 26'h0, 1'b1, 32'h0000_0203, 0);
        check("br_align", fetch_addr, 32'h200);
        do_instr(2, 1'b0, 26'h0, 1'b1, 32'h4000_0010, 0);
        do_instr(0, 1'b1, 26'h0000040, 1'b1, 32'h1234_5678, 0);
        check("jump_wins", fetch_addr, 32'h4000_0100);

        // Three stalled cycles, then advance by 4.
        do_instr(0, 1'b0, 26'h0, 1'b0, 32'h0, 3);
        check("stall_adv", fetch_addr, 32'h4000_0104);

        // Randomized instruction stream.
        for (int i = 0; i < 40; i++) begin
            int m;
            m = int'($urandom_range(0, 3));
            do_instr(int'($urandom_range(0, 3)), m[1], 26'($urandom), m[0], $urandom,
                     int'($urandom_range(0, 3)));
        end

        // Reset in FETCH, stale acknowledge after release.
        wait_fetch();
        reset = 1'b1;
        #1;
        check("midrst_req", {31'd0, fetch_req}, 32'd0);
        check("midrst_iv", {31'd0, instr_valid}, 32'd0);
        check("midrst_pc", pc, 32'h0);
        step();
        reset = 1'b0;
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
        check("stale_req", {31'd0, fetch_req}, 32'd1);
        check("stale_iv", {31'd0, instr_valid}, 32'd0);
        step();
        check("stale_ignored", {31'd0, fetch_req}, 32'd1);
        check("stale_addr", fetch_addr, 32'h0);
        mpc = 32'h0;
        do_instr(0, 1'b0, 26'h0, 1'b0, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
